mux_arb_reg: RTL and testbench

MUX_ARB_REG -- requirements
Module: mux_arb_reg

---
 rtl/mux_arb_reg_if.sv | 27 ++
 rtl/mux_arb_reg.sv | 94 +++++++++
 tb/tb_mux_arb_reg.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_reg_if.sv
// Bundle of the N-channel request side and the registered output side of mux_arb_reg.
interface mux_arb_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 8
);
   localparam int unsigned SW = $clog2(N);

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SW-1:0]      out_sel;
   logic               out_last;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_sel, out_last, out_valid
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_sel, out_last, out_valid
   );
endinterface

// File: rtl/mux_arb_reg.sv
// N-to-1 burst-aware arbiter (fixed priority or round-robin) feeding a one-deep
// registered output stage; a burst holds the grant until its last beat.
module mux_arb_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 8,
   parameter int unsigned MODE  = 1
) (
   input  logic           clk,
   input  logic           rst,
   mux_arb_reg_if.slave   bus
);
   localparam int unsigned SW = $clog2(N);

   typedef enum logic {StArb, StLock} state_e;

   state_e        state;
   logic [SW-1:0] ptr;
   logic [SW-1:0] lk;
   logic [SW-1:0] g;
   logic [SW-1:0] g_inc;
   logic          gv;
   logic          ld;
   logic          xfer;

   assign ld    = !bus.out_valid | bus.out_ready;
   assign xfer  = ld & gv & !rst;
   assign g_inc = (g == SW'(N - 1)) ? '0 : g + 1'b1;

   // Descending scans so the highest-priority candidate is written last.
   always_comb begin
      int idx;
      idx = 0;
      g   = '0;
      gv  = 1'b0;
      if (state == StLock) begin
         g  = lk;
         gv = bus.in_valid[lk];
      end else if (MODE == 0) begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
               g  = SW'(i);
               gv = 1'b1;
            end
         end
      end else begin
         for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(N);
            if (bus.in_valid[idx]) begin
               g  = SW'(idx);
               gv = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.in_ready = '0;
      if (xfer) begin
         bus.in_ready[g] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
         bus.out_last  <= 1'b0;
         ptr           <= '0;
         lk            <= '0;
         state         <= StArb;
      end else begin
         if (ld) begin
            bus.out_valid <= xfer;
            if (xfer) begin
               bus.out_data <= bus.in_data[int'(g)*int'(WIDTH) +: WIDTH];
               bus.out_sel  <= g;
               bus.out_last <= bus.in_last[g];
            end
         end
         if (xfer) begin
            if (MODE == 1) begin
               ptr <= g_inc;
            end
            if (state == StArb && !bus.in_last[g]) begin
               state <= StLock;
               lk    <= g;
            end else if (state == StLock && bus.in_last[g]) begin
               state <= StArb;
            end
         end
      end
   end
endmodule

// File: tb/tb_mux_arb_reg.sv
// Self-checking bench: a fixed-priority and a round-robin instance share stimulus,
// checked by table vectors, hand sequences and random traffic against a model.
module tb_mux_arb_reg;
   localparam int unsigned W = 32;
   localparam int unsigned N = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_last = '0;
   logic           out_ready = 1'b0;

   mux_arb_reg_if #(.WIDTH(W), .N(N)) b0 ();
   mux_arb_reg_if #(.WIDTH(W), .N(N)) b1 ();

   assign b0.in_data   = in_data;
   assign b0.in_valid  = in_valid;
   assign b0.in_last   = in_last;
   assign b0.out_ready = out_ready;
   assign b1.in_data   = in_data;
   assign b1.in_valid  = in_valid;
   assign b1.in_last   = in_last;
   assign b1.out_ready = out_ready;

   mux_arb_reg #(.WIDTH(W), .N(N), .MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(b0));
   mux_arb_reg #(.WIDTH(W), .N(N), .MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(b1));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: output register contents plus arbitration bookkeeping.
   logic         mv[2];
   logic [W-1:0] md[2];
   int           ms[2];
   logic         ml[2];
   bit           lkd[2];
   int           lch[2];
   int           mptr[2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mv[m] = 1'b0; md[m] = '0; ms[m] = 0; ml[m] = 1'b0;
         lkd[m] = 1'b0; lch[m] = 0; mptr[m] = 0;
      end
   endtask

   // Build the priority order as a list, then take the first requesting channel.
   function automatic int pick(int m, logic [N-1:0] v);
      int order[$];
      if (lkd[m]) return v[lch[m]] ? lch[m] : -1;
      for (int k = 0; k < int'(N); k++) order.push_back(m == 1 ? (mptr[m] + k) % int'(N) : k);
      foreach (order[j]) if (v[order[j]]) return order[j];
      return -1;
   endfunction

   function automatic logic [N-1:0] dut_ready(int m);
      return (m == 0) ? b0.in_ready : b1.in_ready;
   endfunction

   task automatic set_in(logic [N-1:0] v, logic [N-1:0] l, logic o);
      in_valid  = v;
      in_last   = l;
      out_ready = o;
      for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = $urandom;
   endtask

   // Called at a negedge with inputs applied; returns at the following negedge.
   task automatic step();
      int           gr[2];
      logic         ldm[2];
      logic [N-1:0] exr;
      #1;
      for (int m = 0; m < 2; m++) begin
         ldm[m] = !mv[m] | out_ready;
         gr[m]  = ldm[m] ? pick(m, in_valid) : -1;
         exr    = (gr[m] >= 0) ? (8'd1 << gr[m]) : 8'd0;
         chk($sformatf("m%0d in_ready", m), dut_ready(m), exr);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (ldm[m]) begin
            if (gr[m] >= 0) begin
               mv[m] = 1'b1;
               md[m] = in_data[gr[m]*W +: W];
               ms[m] = gr[m];
               ml[m] = in_last[gr[m]];
               if (lkd[m] && ml[m]) lkd[m] = 1'b0;
               else if (!lkd[m] && !ml[m]) begin
                  lkd[m] = 1'b1;
                  lch[m] = gr[m];
               end
               if (m == 1) mptr[m] = (gr[m] + 1) % int'(N);
            end else begin
               mv[m] = 1'b0;
            end
         end
      end
      @(negedge clk);
      chk("m0 out_valid", b0.out_valid, mv[0]);
      chk("m0 out_sel",   b0.out_sel,   ms[0]);
      chk("m0 out_data",  b0.out_data,  md[0]);
      chk("m0 out_last",  b0.out_last,  ml[0]);
      chk("m1 out_valid", b1.out_valid, mv[1]);
      chk("m1 out_sel",   b1.out_sel,   ms[1]);
      chk("m1 out_data",  b1.out_data,  md[1]);
      chk("m1 out_last",  b1.out_last,  ml[1]);
   endtask

   task automatic do_reset();
      set_in(8'hFF, 8'hFF, 1'b1);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst m0 in_ready", b0.in_ready, 8'h00);
      chk("rst m1 in_ready", b1.in_ready, 8'h00);
      chk("rst m0 out_valid", b0.out_valid, 1'b0);
      chk("rst m1 out_valid", b1.out_valid, 1'b0);
      chk("rst m1 out_sel", b1.out_sel, 3'd0);
      chk("rst m1 out_data", b1.out_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic         o;
      int           s1;
      int           s0;
      logic         ov;
   } vec_t;

   initial begin
      vec_t tbl[$];
      // Round-robin sweep, then fixed-priority hold on {2,5,7}, then backpressure.
      for (int i = 0; i < 9; i++) tbl.push_back('{8'hFF, 8'hFF, 1'b1, i % 8, 0, 1'b1});
      tbl.push_back('{8'hA4, 8'hFF, 1'b1, 2, 2, 1'b1});
      tbl.push_back('{8'hA4, 8'hFF, 1'b1, 5, 2, 1'b1});
      tbl.push_back('{8'hA4, 8'hFF, 1'b1, 7, 2, 1'b1});
      tbl.push_back('{8'hA4, 8'hFF, 1'b1, 2, 2, 1'b1});
      for (int i = 0; i < 4; i++) tbl.push_back('{8'hFF, 8'hFF, 1'b0, 2, 2, 1'b1});
      tbl.push_back('{8'hFF, 8'hFF, 1'b1, 3, 0, 1'b1});

      #1;
      do_reset();
      foreach (tbl[i]) begin
         set_in(tbl[i].v, tbl[i].l, tbl[i].o);
         step();
         chk($sformatf("tbl[%0d] m1 sel", i), b1.out_sel, tbl[i].s1);
         chk($sformatf("tbl[%0d] m0 sel", i), b0.out_sel, tbl[i].s0);
         chk($sformatf("tbl[%0d] m1 valid", i), b1.out_valid, tbl[i].ov);
      end

      // Burst on ch3 holds off ch1 and ch6.
      do_reset();
      set_in(8'h02, 8'h02, 1'b1); step(); chk("burst pre sel", b1.out_sel, 3'd1);
      set_in(8'h4A, 8'h42, 1'b1); #1 chk("burst b1 rdy", b1.in_ready, 8'h08);
      step(); chk("burst b1 sel", b1.out_sel, 3'd3);
      set_in(8'h4A, 8'h42, 1'b1); #1 chk("burst b2 rdy", b1.in_ready, 8'h08);
      step(); chk("burst b2 sel", b1.out_sel, 3'd3);
      set_in(8'h4A, 8'h4A, 1'b1); #1 chk("burst b3 rdy", b1.in_ready, 8'h08);
      step(); chk("burst b3 sel", b1.out_sel, 3'd3);
      set_in(8'h42, 8'h42, 1'b1); step(); chk("burst next sel", b1.out_sel, 3'd6);
      set_in(8'h02, 8'h02, 1'b1); step(); chk("burst wrap sel", b1.out_sel, 3'd1);

      // Asynchronous reset in the middle of a lock on ch5.
      do_reset();
      set_in(8'h20, 8'h00, 1'b1); step(); chk("lk5 sel", b1.out_sel, 3'd5);
      set_in(8'h20, 8'h00, 1'b1);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async rst m1 valid", b1.out_valid, 1'b0);
      chk("async rst m0 valid", b0.out_valid, 1'b0);
      chk("async rst m1 rdy", b1.in_ready, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      set_in(8'hFF, 8'hFF, 1'b1); step();
      chk("post rst sel", b1.out_sel, 3'd0);
      chk("post rst valid", b1.out_valid, 1'b1);

      // Lock on ch2 stalls while ch2 idles, even with ch0 requesting.
      do_reset();
      set_in(8'h04, 8'h00, 1'b1); step(); chk("lk2 sel", b1.out_sel, 3'd2);
      for (int i = 0; i < 3; i++) begin
         set_in(8'h01, 8'h01, 1'b1); #1 chk($sformatf("lk2 stall%0d rdy", i), b1.in_ready, 8'h00);
         step(); chk($sformatf("lk2 stall%0d valid", i), b1.out_valid, 1'b0);
      end
      set_in(8'h05, 8'h05, 1'b1); step();
      chk("lk2 resume sel", b1.out_sel, 3'd2);
      chk("lk2 resume valid", b1.out_valid, 1'b1);
      set_in(8'h05, 8'h05, 1'b1); step();
      chk("lk2 after m1 sel", b1.out_sel, 3'd0);
      chk("lk2 after m0 sel", b0.out_sel, 3'd0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] v;
         v = (i % 3 == 0) ? N'($urandom & $urandom) : N'($urandom);
         set_in(v, N'($urandom | $urandom), $urandom_range(0, 3) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
